trivium_rng_scheduler: RTL and testbench

Sequencer and arbiter placed between the 64-bit Trivium keystream generator and the masked (DOM) cipher cores that consume fresh randomness. It seeds the generator, waits for warm-up, and steps the generator exactly once per delivered word. It hands each 64-bit word to one of `NUM_REQ` requesters under round-robin arbitration, and reseeds automatically with a stepped IV after a fixed number of words, so no word is ever delivered twice.

---
 rtl/trivium_rng_scheduler.sv | 149 ++++++++++++++
 tb/tb_trivium_rng_scheduler.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trivium_rng_scheduler.sv
// Seeds a 64-bit Trivium keystream generator and hands each word to one requester (round-robin).
// Optional TRIVIUM_SCHED_HEALTH_EN adds a repetition health check on delivered words.
module trivium_rng_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int RESEED_WORDS = 1024
) (
  input  logic               clk,
  input  logic               nRST,
  input  logic               seed_valid,
  input  logic [79:0]        seed_key,
  input  logic [79:0]        seed_iv,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [63:0]        rnd_data,
  output logic               busy,
  output logic               health_fail,
  output logic               trng_start,
  output logic               trng_enable,
  output logic [79:0]        trng_key,
  output logic [79:0]        trng_iv,
  input  logic               trng_ready,
  input  logic [63:0]        trng_rng
);

  localparam int PW = $clog2(NUM_REQ);
  localparam logic [15:0] RW = 16'(RESEED_WORDS);

  typedef enum logic [2:0] {IDLE, SEED, WARM, SERVE, GAP} state_t;

  state_t        state, next_state;
  logic [79:0]   base_iv, epoch;
  logic [15:0]   word_cnt, cnt_next;
  logic [PW-1:0] ptr, winner, ptr_next;
  logic [PW:0]   idx;
  logic          found, any_req, health_hit, serve_fire, epoch_done;

  // Round-robin search starting at ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(NUM_REQ)) idx = idx - (PW+1)'(NUM_REQ);
      if (!found && req[idx[PW-1:0]]) begin
        found  = 1'b1;
        winner = idx[PW-1:0];
      end
    end
  end

  assign ptr_next    = (winner == PW'(NUM_REQ - 1)) ? '0 : winner + PW'(1);
  assign any_req     = |req;
  assign cnt_next    = word_cnt + 16'd1;
  assign epoch_done  = (cnt_next == RW);
  assign serve_fire  = (state == SERVE) && any_req && !seed_valid && !health_hit;
  assign trng_enable = serve_fire;
  assign trng_start  = (state == SEED);
  assign busy        = (state == IDLE) || (state == SEED) || (state == WARM);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (seed_valid) begin
      next_state = SEED;
    end else begin
      case (state)
        IDLE:  next_state = IDLE;
        SEED:  next_state = WARM;
        WARM:  if (trng_ready) next_state = SERVE;
        SERVE: if (any_req) begin
                 if (health_hit)      next_state = IDLE;
                 else if (epoch_done) next_state = SEED;
                 else                 next_state = GAP;
               end
        GAP:   next_state = SERVE;
        default: next_state = IDLE;
      endcase
    end
  end

  // trng_iv is loaded one cycle early so it is already stable while SEED pulses trng_start.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      gnt      <= '0;
      rnd_data <= '0;
      trng_key <= '0;
      trng_iv  <= '0;
      base_iv  <= '0;
      epoch    <= '0;
      word_cnt <= '0;
      ptr      <= '0;
    end else begin
      gnt <= '0;
      if (seed_valid) begin
        trng_key <= seed_key;
        base_iv  <= seed_iv;
        epoch    <= '0;
        trng_iv  <= seed_iv;
      end else if (serve_fire) begin
        gnt      <= NUM_REQ'(1) << winner;
        rnd_data <= trng_rng;
        ptr      <= ptr_next;
        word_cnt <= cnt_next;
        if (epoch_done) begin
          epoch   <= epoch + 80'd1;
          trng_iv <= base_iv + epoch + 80'd1;
        end
      end
      if (state == SEED) word_cnt <= '0;
    end
  end

`ifdef TRIVIUM_SCHED_HEALTH_EN
  logic [63:0] last_word;
  logic        have_last;

  assign health_hit = have_last && (trng_rng == last_word);

  // The first word after a seed has nothing to compare against.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      last_word   <= '0;
      have_last   <= 1'b0;
      health_fail <= 1'b0;
    end else begin
      if (seed_valid)
        health_fail <= 1'b0;
      else if ((state == SERVE) && any_req && health_hit)
        health_fail <= 1'b1;
      if (state == SEED) begin
        last_word <= '0;
        have_last <= 1'b0;
      end else if (serve_fire) begin
        last_word <= trng_rng;
        have_last <= 1'b1;
      end
    end
  end
`else
  assign health_hit  = 1'b0;
  assign health_fail = 1'b0;
`endif

endmodule

// File: tb/tb_trivium_rng_scheduler.sv
// Scoreboard bench for trivium_rng_scheduler with a stub keystream generator.
// Health-check scenario runs only when TRIVIUM_SCHED_HEALTH_EN is defined.
module tb_trivium_rng_scheduler;

  localparam int NR = 4;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          nRST;
  logic          seed_valid;
  logic [79:0]   seed_key, seed_iv;
  logic [NR-1:0] req;
  logic [NR-1:0] gnt;
  logic [63:0]   rnd_data;
  logic          busy, health_fail, trng_start, trng_enable, trng_ready;
  logic [79:0]   trng_key, trng_iv;
  logic [63:0]   trng_rng;

  always #5 clk = ~clk;

  trivium_rng_scheduler #(.NUM_REQ(NR), .RESEED_WORDS(RW)) dut (
    .clk(clk), .nRST(nRST), .seed_valid(seed_valid), .seed_key(seed_key), .seed_iv(seed_iv),
    .req(req), .gnt(gnt), .rnd_data(rnd_data), .busy(busy), .health_fail(health_fail),
    .trng_start(trng_start), .trng_enable(trng_enable), .trng_key(trng_key), .trng_iv(trng_iv),
    .trng_ready(trng_ready), .trng_rng(trng_rng)
  );

  // Deterministic stand-in for the keystream: word number s of a (key, iv) seed.
  function automatic logic [63:0] mix(input logic [79:0] k, input logic [79:0] v, input int unsigned s);
    logic [63:0] x;
    x = k[63:0] ^ {v[47:0], k[79:64]} ^ {v[79:48], 32'h0} ^ ({32'h0, s} * 64'h9E3779B97F4A7C15);
    x = x ^ (x >> 31);
    x = x * 64'hBF58476D1CE4E5B9;
    x = x ^ (x >> 29);
    return x;
  endfunction

  logic [79:0] st_key, st_iv;
  int unsigned st_step;
  int          st_warm;
  logic        st_ready;
  logic        stuck;
  logic        en_at_edge;

  // Generator stub: ~20-cycle warm-up after trng_start, one step per enabled cycle.
  always @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      st_key <= '0; st_iv <= '0; st_step <= 0; st_warm <= 0; st_ready <= 1'b0;
    end else if (trng_start) begin
      st_key <= trng_key; st_iv <= trng_iv; st_step <= 0; st_warm <= 20; st_ready <= 1'b0;
    end else begin
      if (st_warm > 0) begin
        st_warm <= st_warm - 1;
        if (st_warm == 1) st_ready <= 1'b1;
      end
      if (trng_enable && st_ready) st_step <= st_step + 1;
    end
  end

  assign trng_ready = st_ready;
  assign trng_rng   = stuck ? 64'hDEADBEEF00000001 : mix(st_key, st_iv, st_step);

  always @(posedge clk) en_at_edge <= trng_enable;

  typedef struct { logic [NR-1:0] g; logic [63:0] w; } gexp_t;
  typedef struct { logic [79:0] iv; logic [79:0] key; } sexp_t;
  gexp_t gq[$];
  sexp_t sq[$];

  int errors = 0;
  int checks = 0;
  int starts = 0;

  logic [79:0] m_key, m_base, m_epoch;
  int          m_k, m_p;

  task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic failNote(input string name, input logic [79:0] act);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=%h required=none", name, act);
  endtask

  task automatic tick();
    @(negedge clk);
    req = req & ~gnt;
  endtask

  task automatic checkReset();
    checkOutput("rst_gnt",      80'(gnt),         80'd0);
    checkOutput("rst_rnd_data", 80'(rnd_data),    80'd0);
    checkOutput("rst_start",    80'(trng_start),  80'd0);
    checkOutput("rst_enable",   80'(trng_enable), 80'd0);
    checkOutput("rst_key",      trng_key,         80'd0);
    checkOutput("rst_iv",       trng_iv,          80'd0);
    checkOutput("rst_health",   80'(health_fail), 80'd0);
    checkOutput("rst_busy",     80'(busy),        80'd1);
  endtask

  // Reference: each member of a fresh request set is served once, in cyclic order from the
  // pointer; every RW words the epoch advances and the generator is restarted with base+epoch.
  function automatic void predict(input logic [NR-1:0] s);
    int p0;
    p0 = m_p;
    for (int n = 0; n < NR; n++) begin
      int ix;
      ix = (p0 + n) % NR;
      if (s[ix]) begin
        gq.push_back('{g: NR'(1) << ix, w: mix(m_key, m_base + m_epoch, m_k)});
        m_k++;
        m_p = (ix + 1) % NR;
        if (m_k == RW) begin
          m_epoch = m_epoch + 80'd1;
          m_k = 0;
          sq.push_back('{iv: m_base + m_epoch, key: m_key});
        end
      end
    end
  endfunction

  task automatic modelSeed(input logic [79:0] k, input logic [79:0] v);
    m_key = k; m_base = v; m_epoch = '0; m_k = 0;
    sq.push_back('{iv: v, key: k});
  endtask

  task automatic applySeed(input logic [79:0] k, input logic [79:0] v);
    seed_key = k; seed_iv = v; seed_valid = 1'b1;
    modelSeed(k, v);
    tick();
    seed_valid = 1'b0;
    checkOutput("start_latency", 80'(trng_start), 80'd1);
    tick();
    checkOutput("start_width", 80'(trng_start), 80'd0);
    checkOutput("busy_warm",   80'(busy),       80'd1);
  endtask

  task automatic waitServe();
    int n = 0;
    while (busy && n < 200) begin tick(); n++; end
    if (busy) failNote("serve_timeout", 80'(busy));
  endtask

  task automatic drain();
    int n = 0;
    while (req != '0 && n < 500) begin tick(); n++; end
    if (req != '0) failNote("grant_timeout", 80'(req));
  endtask

  task automatic applyStimulus(input logic [NR-1:0] s);
    drain();
    predict(s);
    req = s;
    repeat ($urandom_range(0, 2)) tick();
  endtask

  initial begin
    logic [NR-1:0] s;
    logic [NR-1:0] prev_gnt;
    int            s0;
    nRST = 1'b0; seed_valid = 1'b0; seed_key = '0; seed_iv = '0; req = '0; stuck = 1'b0;
    m_key = '0; m_base = '0; m_epoch = '0; m_k = 0; m_p = 0;
    prev_gnt = '0;

    fork
      forever begin
        gexp_t ge;
        sexp_t se;
        @(negedge clk);
        if (!nRST) begin
          prev_gnt = '0;
        end else begin
          if (trng_start) begin
            starts++;
            if (sq.size() == 0) failNote("unexpected_start", trng_iv);
            else begin
              se = sq.pop_front();
              checkOutput("trng_iv",  trng_iv,  se.iv);
              checkOutput("trng_key", trng_key, se.key);
            end
          end
          if (gnt != '0) begin
            if (gq.size() == 0) failNote("unexpected_gnt", 80'(gnt));
            else begin
              ge = gq.pop_front();
              checkOutput("gnt",      80'(gnt),      80'(ge.g));
              checkOutput("rnd_data", 80'(rnd_data), 80'(ge.w));
            end
            checkOutput("enable_before_gnt", 80'(en_at_edge), 80'd1);
            checkOutput("gnt_spacing", 80'(prev_gnt != '0), 80'd0);
          end
          prev_gnt = gnt;
        end
      end
    join_none

    #2 checkReset();
    repeat (3) @(negedge clk);
    nRST = 1'b1;
    tick();

    $display("[TB] seed bring-up");
    applySeed(80'h0123456789ABCDEF0123, 80'hA5A5A5A5A5A5A5A5A5A5);
    waitServe();
    checkOutput("busy_serve", 80'(busy), 80'd0);
    applyStimulus(4'b0001);

    $display("[TB] round-robin and auto reseed");
    applyStimulus(4'b1111);
    applyStimulus(4'b1111);
    for (int i = 0; i < 12; i++) begin
      s = 4'($urandom_range(1, 15));
      applyStimulus(s);
    end
    drain();

    $display("[TB] preemption");
    repeat (3) tick();
    waitServe();
    seed_key = 80'hFEDCBA98765432100FED; seed_iv = 80'h0000000000000000FFFF;
    seed_valid = 1'b1;
    modelSeed(seed_key, seed_iv);
    predict(4'b0101);
    req = 4'b0101;
    #1 checkOutput("preempt_enable", 80'(trng_enable), 80'd0);
    tick();
    seed_valid = 1'b0;
    checkOutput("preempt_gnt",   80'(gnt),        80'd0);
    checkOutput("preempt_start", 80'(trng_start), 80'd1);
    waitServe();
    drain();

    $display("[TB] reset mid-WARM");
    applySeed(80'h13579BDF02468ACE1357, 80'hFFFFFFFFFFFFFFFFFFFE);
    repeat (5) tick();
    #2 nRST = 1'b0;
    #1 checkReset();
    m_p = 0;
    tick(); tick();
    nRST = 1'b1;
    s0 = starts;
    repeat (40) tick();
    checkOutput("no_restart", 80'(starts - s0), 80'd0);
    checkOutput("busy_idle",  80'(busy),        80'd1);

    applySeed(80'h0F0F0F0F0F0F0F0F0F0F, 80'hFFFFFFFFFFFFFFFFFFFD);
    waitServe();
    for (int i = 0; i < 8; i++) begin
      s = 4'($urandom_range(1, 15));
      applyStimulus(s);
    end
    drain();

`ifdef TRIVIUM_SCHED_HEALTH_EN
    $display("[TB] health check");
    stuck = 1'b1;
    applySeed(80'h11111111111111111111, 80'h22222222222222222222);
    waitServe();
    gq.push_back('{g: NR'(1) << m_p, w: 64'hDEADBEEF00000001});
    req = NR'(1) << m_p;
    m_p = (m_p + 1) % NR;
    m_k++;
    drain();
    repeat (3) tick();
    req = NR'(1) << m_p;
    repeat (6) tick();
    checkOutput("health_fail_set", 80'(health_fail), 80'd1);
    checkOutput("health_busy",     80'(busy),        80'd1);
    checkOutput("health_req_held", 80'(req != '0),   80'd1);
    req = '0;
    stuck = 1'b0;
    applySeed(80'h33333333333333333333, 80'h44444444444444444444);
    checkOutput("health_clear", 80'(health_fail), 80'd0);
    waitServe();
    applyStimulus(4'b1111);
    drain();
`endif

    repeat (4) tick();
    checkOutput("health_fail_end",   80'(health_fail), 80'd0);
    checkOutput("grant_queue_empty", 80'(gq.size()),   80'd0);
    checkOutput("start_queue_empty", 80'(sq.size()),   80'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
